// File: rtl/piano_pkg.sv
// Shared definitions for the piano auto-play path: note codes, the note-to-Led
// mapping, step-word layout, sequencer states and the song ROM contents.
package piano_pkg;

  localparam int NOTE_W    = 4;
  localparam int ROM_DUR_W = 4;

  localparam logic [NOTE_W-1:0] NOTE_C5   = 4'h0;
  localparam logic [NOTE_W-1:0] NOTE_B    = 4'h1;
  localparam logic [NOTE_W-1:0] NOTE_A    = 4'h2;
  localparam logic [NOTE_W-1:0] NOTE_G    = 4'h3;
  localparam logic [NOTE_W-1:0] NOTE_F    = 4'h4;
  localparam logic [NOTE_W-1:0] NOTE_E    = 4'h5;
  localparam logic [NOTE_W-1:0] NOTE_D    = 4'h6;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'h7;
  localparam logic [NOTE_W-1:0] NOTE_NONE = 4'h8;

  typedef struct packed {
    logic [NOTE_W-1:0]    code;
    logic [ROM_DUR_W-1:0] dur;   // 0 marks end of song
  } step_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PLAY,
    S_DONE
  } seq_state_t;

  // Codes 0..7 light Led[7-code]; "none" is dark; anything else lights all.
  function automatic logic [7:0] note_to_led(input logic [NOTE_W-1:0] code);
    logic [7:0] led;
    if (code < 4'h8)       led = 8'h01 << (3'd7 - code[2:0]);
    else if (code == 4'h8) led = 8'h00;
    else                   led = 8'hFF;
    return led;
  endfunction

  // Song table. Unlisted steps read as the end-of-song marker.
  //   0: Ode to Joy, 1: ascending scale, 2: three-step test song,
  //   3: every step filled (no end marker) to exercise the last-step wrap.
  function automatic step_word_t song_step(input int song, input int step);
    step_word_t w;
    w = '{NOTE_NONE, 4'd0};
    case (song)
      0: begin
        case (step)
          0, 1, 6, 11: w = '{NOTE_E, 4'd2};
          2, 5:        w = '{NOTE_F, 4'd2};
          3, 4:        w = '{NOTE_G, 4'd2};
          7, 10:       w = '{NOTE_D, 4'd2};
          8, 9:        w = '{NOTE_C4, 4'd2};
          12:          w = '{NOTE_E, 4'd3};
          13:          w = '{NOTE_D, 4'd1};
          14:          w = '{NOTE_D, 4'd4};
          default:     ;
        endcase
      end
      1: begin
        case (step)
          0:       w = '{NOTE_C4, 4'd1};
          1:       w = '{NOTE_D, 4'd1};
          2:       w = '{NOTE_E, 4'd1};
          3:       w = '{NOTE_F, 4'd1};
          4:       w = '{NOTE_G, 4'd1};
          5:       w = '{NOTE_A, 4'd1};
          6:       w = '{NOTE_B, 4'd1};
          7:       w = '{NOTE_C5, 4'd1};
          default: ;
        endcase
      end
      2: begin
        case (step)
          0:       w = '{NOTE_C5, 4'd1};
          1:       w = '{NOTE_A, 4'd2};
          2:       w = '{NOTE_F, 4'd1};
          default: ;
        endcase
      end
      3:       w = '{4'(step % 8), 4'd1};
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/song_rom.sv
// Synchronous-read song ROM, address {song, step}, one cycle of latency.
module song_rom
  import piano_pkg::*;
#(
  parameter  int NUM_SONGS  = 4,
  parameter  int SONG_DEPTH = 64,
  parameter  int DUR_W      = 4,
  localparam int SEL_W      = $clog2(NUM_SONGS),
  localparam int STEP_W     = $clog2(SONG_DEPTH),
  localparam int WORD_W     = NOTE_W + DUR_W
) (
  input  logic                    clk,
  input  logic [SEL_W+STEP_W-1:0] i_addr,
  output logic [WORD_W-1:0]       o_word
);

  step_word_t        w_entry;
  logic [WORD_W-1:0] r_word;

  // Table lookup for the presented address.
  always_comb begin
    w_entry = song_step(int'(i_addr[SEL_W+STEP_W-1:STEP_W]), int'(i_addr[STEP_W-1:0]));
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    r_word <= {w_entry.code, DUR_W'(w_entry.dur)};
  end

  assign o_word = r_word;

endmodule

// File: rtl/song_sequencer.sv
// Auto-play note sequencer: steps through a ROM song, timing each note with a
// tick counter on the system clock and inserting a silent gap at note ends.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | stopped, silent; waits for play to latch song and start
// S_FETCH  | ROM address presented for the current step
// S_DECODE | ROM word valid; end marker or load a new note
// S_PLAY   | note sounding; rem counts ticks left in the step
// S_DONE   | song finished, silent; exits on restart or play low
module song_sequencer
  import piano_pkg::*;
#(
  parameter  int NUM_SONGS  = 4,
  parameter  int SONG_DEPTH = 64,
  parameter  int DUR_W      = 4,
  parameter  int TICK_W     = 24,
  parameter  int GAP_TICKS  = 1,
  localparam int SEL_W      = $clog2(NUM_SONGS),
  localparam int STEP_W     = $clog2(SONG_DEPTH)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              play,
  input  logic              restart,
  input  logic [SEL_W-1:0]  song_sel,
  input  logic              loop_en,
  input  logic [TICK_W-1:0] tick_len,
  output logic [3:0]        note,
  output logic [7:0]        Led,
  output logic [STEP_W-1:0] step_idx,
  output logic              playing,
  output logic              done
);

  localparam logic [DUR_W-1:0] GAP_D = DUR_W'(GAP_TICKS);

  seq_state_t               r_state;
  logic [SEL_W-1:0]         r_song;
  logic [STEP_W-1:0]        r_step;
  logic [NOTE_W-1:0]        r_code;
  logic [DUR_W-1:0]         r_dur;
  logic [DUR_W-1:0]         r_rem;
  logic [TICK_W-1:0]        r_cnt;
  logic [NOTE_W-1:0]        r_note;
  logic                     r_playing;
  logic                     r_done;

  logic [NOTE_W+DUR_W-1:0]  w_rom_word;
  logic [NOTE_W-1:0]        w_rom_code;
  logic [DUR_W-1:0]         w_rom_dur;
  logic [TICK_W-1:0]        w_tick_last;
  logic                     w_tick;
  logic                     w_last_step;
  logic [DUR_W-1:0]         w_rem_next;
  logic [NOTE_W-1:0]        w_note_play;

  song_rom #(
    .NUM_SONGS  (NUM_SONGS),
    .SONG_DEPTH (SONG_DEPTH),
    .DUR_W      (DUR_W)
  ) u_rom (
    .clk    (clk),
    .i_addr ({r_song, r_step}),
    .o_word (w_rom_word)
  );

  assign w_rom_code  = w_rom_word[NOTE_W+DUR_W-1:DUR_W];
  assign w_rom_dur   = w_rom_word[DUR_W-1:0];
  // tick_len of 0 behaves as 1; >= keeps a live shrink of tick_len from wrapping.
  assign w_tick_last = (tick_len == '0) ? '0 : tick_len - 1'b1;
  assign w_tick      = (r_cnt >= w_tick_last);
  assign w_last_step = (r_step == STEP_W'(SONG_DEPTH - 1));
  assign w_rem_next  = w_tick ? r_rem - DUR_W'(1) : r_rem;
  // Notes no longer than the gap sound for their whole duration.
  assign w_note_play = (w_rem_next > GAP_D || r_dur <= GAP_D) ? r_code : NOTE_NONE;

  // Sequencer FSM with tick/step/rem counters and registered outputs.
  always_ff @(posedge clk) begin
    r_done <= 1'b0;
    if (RESET) begin
      r_state   <= S_IDLE;
      r_song    <= '0;
      r_step    <= '0;
      r_code    <= NOTE_NONE;
      r_dur     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_note    <= NOTE_NONE;
      r_playing <= 1'b0;
    end else if (restart) begin
      r_step    <= '0;
      r_song    <= song_sel;
      r_note    <= NOTE_NONE;
      r_cnt     <= '0;
      r_state   <= play ? S_FETCH : S_IDLE;
      r_playing <= play;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_note <= NOTE_NONE;
          if (play) begin
            r_song    <= song_sel;
            r_step    <= '0;
            r_state   <= S_FETCH;
            r_playing <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!play) r_note  <= NOTE_NONE;
          else       r_state <= S_DECODE;
        end
        S_DECODE: begin
          if (!play) begin
            r_note <= NOTE_NONE;
          end else if (w_rom_dur == '0) begin
            if (loop_en) begin
              r_step  <= '0;
              r_state <= S_FETCH;
            end else begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_playing <= 1'b0;
              r_note    <= NOTE_NONE;
            end
          end else begin
            r_code  <= w_rom_code;
            r_dur   <= w_rom_dur;
            r_rem   <= w_rom_dur;
            r_cnt   <= '0;
            r_note  <= w_rom_code;
            r_state <= S_PLAY;
          end
        end
        S_PLAY: begin
          if (!play) begin
            r_note <= NOTE_NONE;
          end else if (w_tick && r_rem <= DUR_W'(1)) begin
            r_cnt <= '0;
            if (!w_last_step) begin
              r_step  <= r_step + 1'b1;
              r_state <= S_FETCH;
            end else if (loop_en) begin
              r_step  <= '0;
              r_state <= S_FETCH;
            end else begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_playing <= 1'b0;
              r_note    <= NOTE_NONE;
            end
          end else begin
            r_cnt  <= w_tick ? '0 : r_cnt + 1'b1;
            r_rem  <= w_rem_next;
            r_note <= w_note_play;
          end
        end
        S_DONE: begin
          r_note <= NOTE_NONE;
          if (!play) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note     = r_note;
  assign Led      = note_to_led(r_note);
  assign step_idx = r_step;
  assign playing  = r_playing;
  assign done     = r_done;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: start latency, gap timing, pause, end of
// song, looping, restart, tick_len=0 and the last-step wrap.
module tb_song_sequencer;

  logic        clk = 1'b0;
  logic        RESET, play, restart, loop_en;
  logic [1:0]  song_sel;
  logic [23:0] tick_len;
  logic [3:0]  note;
  logic [7:0]  Led;
  logic [5:0]  step_idx;
  logic        playing, done;

  int n_cmp = 0;
  int n_err = 0;

  song_sequencer dut (
    .clk      (clk),
    .RESET    (RESET),
    .play     (play),
    .restart  (restart),
    .song_sel (song_sel),
    .loop_en  (loop_en),
    .tick_len (tick_len),
    .note     (note),
    .Led      (Led),
    .step_idx (step_idx),
    .playing  (playing),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    step_clk();
    step_clk();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    play = 1'b1; restart = 1'b0; loop_en = 1'b0; song_sel = 2'd0; tick_len = 24'd3;
    do_reset();
    RESET = 1'b1;
    n_cmp++; if (note !== 4'd8)     begin n_err++; $display("FAIL reset_note: got %0d want 8", note); end
    n_cmp++; if (Led !== 8'h00)     begin n_err++; $display("FAIL reset_led: got %h want 00", Led); end
    n_cmp++; if (step_idx !== 6'd0) begin n_err++; $display("FAIL reset_step: got %0d want 0", step_idx); end
    n_cmp++; if (playing !== 1'b0)  begin n_err++; $display("FAIL reset_playing: got %b want 0", playing); end
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    RESET = 1'b0;
    step_clk();
    n_cmp++; if (note !== 4'd8 || Led !== 8'h00) begin n_err++; $display("FAIL start_e0: note %0d led %h want 8/00", note, Led); end
    n_cmp++; if (playing !== 1'b1) begin n_err++; $display("FAIL start_playing: got %b want 1", playing); end
    step_clk();
    n_cmp++; if (note !== 4'd8 || Led !== 8'h00) begin n_err++; $display("FAIL start_e1: note %0d led %h want 8/00", note, Led); end
    step_clk();
    n_cmp++; if (note !== 4'd5 || Led !== 8'b0000_0100) begin n_err++; $display("FAIL start_e2: note %0d led %h want 5/04", note, Led); end
  endtask

  task automatic test_gap_timing();
    logic [3:0] exp_seq [19];
    exp_seq = '{4'd8, 4'd8, 4'd5, 4'd5, 4'd5, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8,
                4'd5, 4'd5, 4'd5, 4'd8, 4'd8, 4'd8, 4'd8, 4'd8, 4'd4};
    play = 1'b1; loop_en = 1'b0; song_sel = 2'd0; tick_len = 24'd3;
    do_reset();
    for (int i = 0; i < 19; i++) begin
      step_clk();
      n_cmp++;
      if (note !== exp_seq[i]) begin n_err++; $display("FAIL gap_seq edge %0d: got %0d want %0d", i, note, exp_seq[i]); end
    end
    n_cmp++; if (step_idx !== 6'd2) begin n_err++; $display("FAIL gap_step: got %0d want 2", step_idx); end
    n_cmp++; if (Led !== 8'b0000_1000) begin n_err++; $display("FAIL gap_led_f: got %h want 08", Led); end
  endtask

  task automatic test_pause();
    int bad, sounded;
    play = 1'b1; loop_en = 1'b0; song_sel = 2'd0; tick_len = 24'd3;
    do_reset();
    for (int i = 0; i < 3; i++) step_clk();
    n_cmp++; if (note !== 4'd5) begin n_err++; $display("FAIL pause_pre: got %0d want 5", note); end
    play = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step_clk();
      if (note !== 4'd8) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL pause_silent: %0d sounding cycles want 0", bad); end
    n_cmp++; if (step_idx !== 6'd0 || playing !== 1'b1) begin n_err++; $display("FAIL pause_frozen: step %0d playing %b want 0/1", step_idx, playing); end
    play = 1'b1;
    sounded = 0;
    for (int i = 0; i < 7; i++) begin
      step_clk();
      if (note === 4'd5) sounded++;
    end
    n_cmp++; if (sounded !== 2) begin n_err++; $display("FAIL pause_remaining: got %0d want 2", sounded); end
    step_clk();
    n_cmp++; if (note !== 4'd5 || step_idx !== 6'd1) begin n_err++; $display("FAIL pause_next: note %0d step %0d want 5/1", note, step_idx); end
  endtask

  task automatic test_done();
    logic [3:0] ns [15];
    logic       pl [15];
    int         n_done, done_edge;
    play = 1'b1; loop_en = 1'b0; song_sel = 2'd2; tick_len = 24'd0;
    do_reset();
    n_done = 0; done_edge = -1;
    for (int e = 0; e < 15; e++) begin
      step_clk();
      ns[e] = note; pl[e] = playing;
      if (done === 1'b1) begin n_done++; done_edge = e; end
      if (e == 12) begin
        n_cmp++; if (step_idx !== 6'd3) begin n_err++; $display("FAIL done_step: got %0d want 3", step_idx); end
      end
    end
    n_cmp++; if (n_done !== 1)     begin n_err++; $display("FAIL done_count: got %0d want 1", n_done); end
    n_cmp++; if (done_edge !== 12) begin n_err++; $display("FAIL done_edge: got %0d want 12", done_edge); end
    n_cmp++; if (ns[2] !== 4'd0)   begin n_err++; $display("FAIL done_c5: got %0d want 0", ns[2]); end
    n_cmp++; if (ns[5] !== 4'd2)   begin n_err++; $display("FAIL done_a: got %0d want 2", ns[5]); end
    n_cmp++; if (ns[6] !== 4'd8)   begin n_err++; $display("FAIL done_gap: got %0d want 8", ns[6]); end
    n_cmp++; if (ns[9] !== 4'd4 || ns[10] !== 4'd4) begin n_err++; $display("FAIL done_short_note: got %0d,%0d want 4,4", ns[9], ns[10]); end
    n_cmp++; if (ns[12] !== 4'd8 || pl[12] !== 1'b0 || pl[11] !== 1'b1) begin n_err++; $display("FAIL done_state: note %0d playing %b/%b want 8 1->0", ns[12], pl[11], pl[12]); end
    restart = 1'b1;
    step_clk();
    restart = 1'b0;
    n_cmp++; if (playing !== 1'b1 || step_idx !== 6'd0 || done !== 1'b0) begin n_err++; $display("FAIL done_exit: playing %b step %0d done %b want 1/0/0", playing, step_idx, done); end
  endtask

  task automatic test_loop();
    int n_done;
    play = 1'b1; loop_en = 1'b1; song_sel = 2'd2; tick_len = 24'd0;
    do_reset();
    n_done = 0;
    for (int e = 0; e < 15; e++) begin
      step_clk();
      if (done === 1'b1) n_done++;
      if (e == 12) begin
        n_cmp++; if (step_idx !== 6'd0 || playing !== 1'b1) begin n_err++; $display("FAIL loop_wrap: step %0d playing %b want 0/1", step_idx, playing); end
      end
      if (e == 14) begin
        n_cmp++; if (note !== 4'd0 || Led !== 8'h80) begin n_err++; $display("FAIL loop_first: note %0d led %h want 0/80", note, Led); end
      end
    end
    n_cmp++; if (n_done !== 0) begin n_err++; $display("FAIL loop_no_done: got %0d pulses want 0", n_done); end
  endtask

  task automatic test_restart();
    int found;
    play = 1'b1; loop_en = 1'b0; song_sel = 2'd0; tick_len = 24'd0;
    do_reset();
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step_clk();
      if (step_idx === 6'd5) found = 1;
    end
    n_cmp++; if (found !== 1) begin n_err++; $display("FAIL restart_reach: step_idx 5 not reached, at %0d", step_idx); end
    step_clk();
    song_sel = 2'd1; restart = 1'b1;
    step_clk();
    restart = 1'b0; song_sel = 2'd2;
    n_cmp++; if (note !== 4'd8 || step_idx !== 6'd0) begin n_err++; $display("FAIL restart_r0: note %0d step %0d want 8/0", note, step_idx); end
    step_clk();
    n_cmp++; if (note !== 4'd8) begin n_err++; $display("FAIL restart_r1: got %0d want 8", note); end
    step_clk();
    n_cmp++; if (note !== 4'd7 || Led !== 8'h01) begin n_err++; $display("FAIL restart_first: note %0d led %h want 7/01", note, Led); end
    for (int i = 0; i < 3; i++) step_clk();
    n_cmp++; if (note !== 4'd6 || step_idx !== 6'd1) begin n_err++; $display("FAIL restart_song_kept: note %0d step %0d want 6/1", note, step_idx); end
  endtask

  task automatic test_play_fall_restart();
    play = 1'b1; loop_en = 1'b0; song_sel = 2'd0; tick_len = 24'd3;
    do_reset();
    for (int i = 0; i < 5; i++) step_clk();
    play = 1'b0; restart = 1'b1;
    step_clk();
    restart = 1'b0;
    n_cmp++; if (playing !== 1'b0 || note !== 4'd8 || step_idx !== 6'd0) begin n_err++; $display("FAIL fall_restart: playing %b note %0d step %0d want 0/8/0", playing, note, step_idx); end
    step_clk(); step_clk();
    n_cmp++; if (playing !== 1'b0) begin n_err++; $display("FAIL fall_idle: got %b want 0", playing); end
    play = 1'b1; song_sel = 2'd2;
    for (int i = 0; i < 3; i++) step_clk();
    n_cmp++; if (note !== 4'd0) begin n_err++; $display("FAIL idle_start_song2: got %0d want 0", note); end
  endtask

  task automatic test_last_step();
    int done_edge;
    play = 1'b1; loop_en = 1'b0; song_sel = 2'd3; tick_len = 24'd0;
    do_reset();
    done_edge = -1;
    for (int e = 0; e < 300 && done_edge < 0; e++) begin
      step_clk();
      if (e == 32) begin
        n_cmp++; if (note !== 4'd2) begin n_err++; $display("FAIL last_mid_note: got %0d want 2", note); end
      end
      if (done === 1'b1) done_edge = e;
    end
    n_cmp++; if (done_edge !== 192) begin n_err++; $display("FAIL last_done_edge: got %0d want 192", done_edge); end
    n_cmp++; if (step_idx !== 6'd63 || note !== 4'd8) begin n_err++; $display("FAIL last_state: step %0d note %0d want 63/8", step_idx, note); end
  endtask

  initial begin
    RESET = 1'b1; play = 1'b0; restart = 1'b0; loop_en = 1'b0;
    song_sel = 2'd0; tick_len = 24'd1;
    test_reset();
    test_gap_timing();
    test_pause();
    test_done();
    test_loop();
    test_restart();
    test_play_fall_restart();
    test_last_step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
